alu_ram_seq: RTL and testbench
==============================

// Module: alu_ram_seq
// PURPOSE
//  Command sequencer for the shared 32-bit alu: takes one 3-address command
//  (op, ra, rb, rd), reads both operands from a single-port synchronous RAM,
//  drives the alu, and writes the result back to RAM[rd].
//  Sits between the command source and the data RAM; owns the RAM port while busy.
// PARAMETERS
//  AW   8    RAM address width (depth 2**AW words)
//  DW   32   data width; fixed at 32 to match alu operand width
// PORTS
//  clk        in   1    single clock, all logic on posedge
//  rst        in   1    synchronous, active-high reset
//  cmd_valid  in   1    command present
//  cmd_ready  out  1    sequencer can accept; high only in IDLE
//  cmd_op     in   5    alu opcode (0..6 legal)
//  cmd_ra     in   AW   operand A address
//  cmd_rb     in   AW   operand B address
//  cmd_rd     in   AW   destination address
//  ram_addr   out  AW   RAM address
//  ram_we     out  1    RAM write enable
//  ram_wdata  out  DW   RAM write data
//  ram_rdata  in   DW   RAM read data, valid 1 cycle after address
//  done       out  1    1-cycle pulse: command retired
//  err        out  1    qualifies done: illegal opcode, no write performed
//  result     out  DW   registered alu result of last retired command
// BEHAVIOUR
//  Reset: state=IDLE, cmd_ready=1, ram_we=0, ram_addr=0, ram_wdata=0,
//   done=0, err=0, result=0; command/operand registers cleared.
//  Reset mid-command: aborts immediately; no write, no done.
//  Accept: cmd_valid&&cmd_ready at edge -> latch op/ra/rb/rd, go RD_A.
//  FSM (one state per cycle, no stalls):
//   IDLE  -> RD_A on accept, else stay
//   RD_A  : ram_addr=ra_q                      -> RD_B
//   RD_B  : ram_addr=rb_q; a_q<=ram_rdata      -> CAP_B
//   CAP_B : b_q<=ram_rdata                     -> WB
//   WB    : alu(a_q,b_q,op_q); ram_addr=rd_q; ram_wdata=alu out;
//           ram_we=1 only if op in 1..6; result<=alu out -> IDLE
//  done/err registered: pulse in cycle after WB, with cmd_ready already high.
//  Latency: accept edge T -> write at edge T+4 -> done high in cycle T+5.
//  Throughput: 1 command per 5 cycles; back-to-back accept allowed on done cycle.
//  Op 0 (NOP): no write, result=0, done=1, err=0.
//  Op 7..31: no write, result=0, done=1, err=1.
//  Arithmetic: alu semantics, 32-bit two's complement, add/sub wrap mod 2**32,
//   no overflow flag.
//  Aliasing: ra==rb, rd==ra or rd==rb legal; write lands after both reads,
//   so next command sees the new value.
//  ram_addr/ram_we/ram_wdata decoded from state regs; ram_we never high outside WB.
//  cmd_* ignored when cmd_ready=0.
// STRUCTURE
//  Shared header alu_defs.vh: opcode localparams ALU_NOP=0, ADD=1, SUB=2, AND=3,
//   OR=4, XOR=5, NOR=6, ALU_OP_MAX=6; FSM state encodings for this block.
//  Sub-module: instantiate existing alu (a_q, b_q, op_q); no other hierarchy.
//  RAM is external; bench supplies a behavioural sync RAM model.
// TESTING
//  1 RAM[1]=5, RAM[2]=7; cmd ADD ra=1 rb=2 rd=3 -> RAM[3]=12, done at T+5, err=0.
//  2 RAM[1]=3, RAM[2]=5; SUB ra=1 rb=2 rd=1 -> RAM[1]=32'hFFFF_FFFE;
//    then ADD ra=1 rb=1 rd=4 issued on done cycle -> RAM[4]=32'hFFFF_FFFC.
//  3 RAM[0]=32'hFFFF_FFFF, RAM[5]=1; ADD -> 0 (wrap); NOR 0,0 -> 32'hFFFF_FFFF.
//  4 op=9 rd=6 -> done=1, err=1, ram_we never asserted, RAM[6] unchanged;
//    op=0 -> done=1, err=0, no write.
//  5 rst asserted in CAP_B -> next cycle IDLE, cmd_ready=1, no write, no done.
//  6 cmd_valid held with changing fields while busy -> only first accepted;
//    AND/OR/XOR of 32'hF0F0_F0F0, 32'h0FF0_0FF0 -> 32'h00F0_00F0 /
//    32'hFFF0_FFF0 / 32'hFF00_FF00.

Source files
------------

// File: rtl/alu_ram_seq_pkg.sv
// rtl/alu_ram_seq_pkg.sv - shared opcodes, FSM states and opcode helpers for alu_ram_seq
package alu_ram_seq_pkg;

  localparam int ALU_W = 32;
  localparam int OP_W  = 5;

  localparam logic [OP_W-1:0] ALU_NOP    = 5'd0;
  localparam logic [OP_W-1:0] ALU_ADD    = 5'd1;
  localparam logic [OP_W-1:0] ALU_SUB    = 5'd2;
  localparam logic [OP_W-1:0] ALU_AND    = 5'd3;
  localparam logic [OP_W-1:0] ALU_OR     = 5'd4;
  localparam logic [OP_W-1:0] ALU_XOR    = 5'd5;
  localparam logic [OP_W-1:0] ALU_NOR    = 5'd6;
  localparam logic [OP_W-1:0] ALU_OP_MAX = 5'd6;

  // One state per cycle: two address phases, two capture phases (RD_B doubles
  // as capture of A), then the write-back.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_CAP_B = 3'd3,
    ST_WB    = 3'd4
  } seq_state_e;

  // Opcodes that produce a RAM write (NOP and illegal ones never write).
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return (op != ALU_NOP) && (op <= ALU_OP_MAX);
  endfunction

  // Opcodes outside the alu's defined range; these retire with err set.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_ram_seq_alu.sv
// rtl/alu_ram_seq_alu.sv - combinational 32-bit alu shared by the sequencer
module alu_ram_seq_alu
  import alu_ram_seq_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [ALU_W-1:0] y
);

  // Opcode decode; NOP and illegal opcodes yield zero so result reads back 0.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_ram_seq.sv
// rtl/alu_ram_seq.sv - 3-address command sequencer: read two RAM words, alu, write back
module alu_ram_seq
  import alu_ram_seq_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_op,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] result
);

  seq_state_e state_q, state_d;

  logic [OP_W-1:0] op_q, op_d;
  logic [AW-1:0]   ra_q, ra_d;
  logic [AW-1:0]   rb_q, rb_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   result_q, result_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [DW-1:0]   alu_y;

  alu_ram_seq_alu u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  // Next-state and capture logic; every state lasts exactly one cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          ra_d    = cmd_ra;
          rb_d    = cmd_rb;
          rd_d    = cmd_rd;
          state_d = ST_RD_A;
        end
      end
      ST_RD_A: begin
        state_d = ST_RD_B;
      end
      ST_RD_B: begin
        // RAM returns the word addressed in RD_A during this cycle.
        a_d     = ram_rdata;
        state_d = ST_CAP_B;
      end
      ST_CAP_B: begin
        b_d     = ram_rdata;
        state_d = ST_WB;
      end
      ST_WB: begin
        result_d = alu_y;
        done_d   = 1'b1;
        err_d    = op_illegal(op_q);
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // RAM port decode from state; write is masked by rst so a reset in WB drops it.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state_q)
      ST_RD_A: ram_addr = ra_q;
      ST_RD_B: ram_addr = rb_q;
      ST_WB: begin
        ram_addr  = rd_q;
        ram_wdata = alu_y;
        ram_we    = op_writes(op_q) && !rst;
      end
      default: ram_addr = '0;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;

endmodule

// File: tb/tb_alu_ram_seq.sv
// tb/tb_alu_ram_seq.sv - scoreboard bench for alu_ram_seq with behavioural sync RAM
module tb_alu_ram_seq;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_op;
  logic [AW-1:0] cmd_ra, cmd_rb, cmd_rd;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          done, err;
  logic [DW-1:0] result;

  logic [DW-1:0] mem [256];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_data;
  int            wr_count;
  int            wr_base;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] res;
    logic          wr;
    logic          err;
    logic [DW-1:0] keep;
  } exp_t;

  exp_t sb[$];
  int compared;
  int mismatched;

  always #5 clk = ~clk;

  alu_ram_seq #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_rd    (cmd_rd),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
    ram_rdata <= mem[ram_addr];
    if (ram_we) wr_count <= wr_count + 1;
  end

  task automatic ram_set(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic [AW-1:0] rd, input logic [DW-1:0] res, input logic wr,
                      input logic e_err, output int waits);
    exp_t e;
    e.rd = rd; e.res = res; e.wr = wr; e.err = e_err; e.keep = mem[rd];
    sb.push_back(e);
    wr_base   = wr_count;
    cmd_op    = op;
    cmd_ra    = ra;
    cmd_rb    = rb;
    cmd_rd    = rd;
    cmd_valid = 1'b1;
    waits     = 0;
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    compared++;
    if (!cmd_ready) begin
      mismatched++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_retire(input logic junk, input string name);
    exp_t e;
    int n;
    logic [DW-1:0] want_mem;
    e = sb.pop_front();
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (junk) begin
        if (!cmd_ready) begin
          cmd_valid = 1'b1;
          cmd_op    = 5'($urandom_range(1, 6));
          cmd_ra    = 8'd10;
          cmd_rb    = 8'd11;
          cmd_rd    = 8'd200;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (done) break;
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL %s done_timeout: done=%b required 1 within 20 cycles", name, done);
    end else if (n != 5) begin
      mismatched++;
      $display("FAIL %s latency: done after %0d cycles required 5", name, n);
    end
    compared++;
    if (err !== e.err) begin
      mismatched++;
      $display("FAIL %s err: got %b required %b", name, err, e.err);
    end
    compared++;
    if (result !== e.res) begin
      mismatched++;
      $display("FAIL %s result: got %h required %h", name, result, e.res);
    end
    want_mem = e.wr ? e.res : e.keep;
    compared++;
    if (mem[e.rd] !== want_mem) begin
      mismatched++;
      $display("FAIL %s ram[%0d]: got %h required %h", name, e.rd, mem[e.rd], want_mem);
    end
    compared++;
    if ((wr_count - wr_base) != (e.wr ? 1 : 0)) begin
      mismatched++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_count - wr_base, e.wr ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; tb_we = 1'b0;
    cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
    tb_addr = '0; tb_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: ready/done/err=%b%b%b required 100", cmd_ready, done, err);
    end
    compared++;
    if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
      mismatched++;
      $display("FAIL reset_ram: we=%b addr=%h wdata=%h required 0/0/0", ram_we, ram_addr, ram_wdata);
    end
    compared++;
    if (result !== '0) begin
      mismatched++;
      $display("FAIL reset_result: got %h required 0", result);
    end
  endtask

  task automatic test_add();
    int w;
    ram_set(8'd1, 32'd5);
    ram_set(8'd2, 32'd7);
    send(5'd1, 8'd1, 8'd2, 8'd3, 32'd12, 1'b1, 1'b0, w);
    wait_retire(1'b0, "add");
  endtask

  task automatic test_back_to_back();
    int w;
    ram_set(8'd1, 32'd3);
    ram_set(8'd2, 32'd5);
    send(5'd2, 8'd1, 8'd2, 8'd1, 32'hFFFF_FFFE, 1'b1, 1'b0, w);
    wait_retire(1'b0, "sub_alias");
    send(5'd1, 8'd1, 8'd1, 8'd4, 32'hFFFF_FFFC, 1'b1, 1'b0, w);
    compared++;
    if (w != 0) begin
      mismatched++;
      $display("FAIL b2b_accept: waited %0d cycles required 0", w);
    end
    wait_retire(1'b0, "add_b2b");
  endtask

  task automatic test_wrap();
    int w;
    ram_set(8'd0, 32'hFFFF_FFFF);
    ram_set(8'd5, 32'd1);
    send(5'd1, 8'd0, 8'd5, 8'd8, 32'd0, 1'b1, 1'b0, w);
    wait_retire(1'b0, "add_wrap");
    send(5'd6, 8'd8, 8'd8, 8'd9, 32'hFFFF_FFFF, 1'b1, 1'b0, w);
    wait_retire(1'b0, "nor_zero");
  endtask

  task automatic test_illegal();
    int w;
    ram_set(8'd6, 32'hDEAD_BEEF);
    send(5'd9, 8'd1, 8'd2, 8'd6, 32'd0, 1'b0, 1'b1, w);
    wait_retire(1'b0, "op9");
    send(5'd7, 8'd1, 8'd2, 8'd6, 32'd0, 1'b0, 1'b1, w);
    wait_retire(1'b0, "op7");
    send(5'd31, 8'd1, 8'd2, 8'd6, 32'd0, 1'b0, 1'b1, w);
    wait_retire(1'b0, "op31");
    send(5'd0, 8'd1, 8'd2, 8'd6, 32'd0, 1'b0, 1'b0, w);
    wait_retire(1'b0, "nop");
  endtask

  task automatic test_busy_ignore();
    int w;
    int extra;
    ram_set(8'd10, 32'hF0F0_F0F0);
    ram_set(8'd11, 32'h0FF0_0FF0);
    ram_set(8'd200, 32'hA5A5_5A5A);
    send(5'd3, 8'd10, 8'd11, 8'd12, 32'h00F0_00F0, 1'b1, 1'b0, w);
    wait_retire(1'b1, "and_busy");
    send(5'd4, 8'd10, 8'd11, 8'd13, 32'hFFF0_FFF0, 1'b1, 1'b0, w);
    wait_retire(1'b1, "or_busy");
    send(5'd5, 8'd10, 8'd11, 8'd14, 32'hFF00_FF00, 1'b1, 1'b0, w);
    wait_retire(1'b1, "xor_busy");
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    compared++;
    if (extra != 0 || mem[200] !== 32'hA5A5_5A5A) begin
      mismatched++;
      $display("FAIL busy_ignore: extra_done=%0d ram[200]=%h required 0 / a5a55a5a", extra, mem[200]);
    end
  endtask

  task automatic test_reset_abort();
    int extra;
    ram_set(8'd7, 32'h1234_5678);
    wr_base   = wr_count;
    cmd_op    = 5'd1;
    cmd_ra    = 8'd10;
    cmd_rb    = 8'd11;
    cmd_rd    = 8'd7;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || result !== '0) begin
      mismatched++;
      $display("FAIL abort_state: ready=%b done=%b result=%h required 1/0/0", cmd_ready, done, result);
    end
    rst = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || ram_we) extra++;
    end
    compared++;
    if (extra != 0 || mem[7] !== 32'h1234_5678 || wr_count != wr_base) begin
      mismatched++;
      $display("FAIL abort_nowrite: activity=%0d ram[7]=%h writes=%0d required 0/12345678/0",
               extra, mem[7], wr_count - wr_base);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_wrap();
    test_illegal();
    test_busy_ignore();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
